// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states, port ids and
// default memory geometry.
package memory_arbiter_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker. eligible[0] is the CPU port and
// eligible[1] the loader; on a tie the port not named by last_grant wins.
module rr_pick2
    import memory_arbiter_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    // Pick a winner from the eligible set, alternating on ties.
    always_comb begin
        valid  = |eligible;
        winner = PORT_CPU;
        unique case (eligible)
            2'b01:   winner = PORT_CPU;
            2'b10:   winner = PORT_LDR;
            2'b11:   winner = (last_grant == PORT_LDR) ? PORT_CPU : PORT_LDR;
            default: winner = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing a single-port memory between the CPU (port C)
// and the loader/debug master (port L). Each access takes an arbitration
// cycle (IDLE) followed by an ACCESS cycle; the ack and registered read data
// appear in the IDLE cycle after ACCESS.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    input  logic                  ldr_req,
    input  logic                  ldr_write,
    input  logic [ADDR_WIDTH-1:0] ldr_address,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] memoryIn,
    input  logic [DATA_WIDTH-1:0] memoryOut
);

    state_e                state_q;
    logic                  winner_q;
    logic                  last_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  cpu_ack_q;
    logic                  ldr_ack_q;

    logic [1:0]            eligible;
    logic                  pick_valid;
    logic                  pick_winner;
    logic                  write_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    // A port whose ack is high this cycle is masked so a held req is not re-granted.
    assign eligible = {ldr_req & ~ldr_ack_q, cpu_req & ~cpu_ack_q};

    rr_pick2 u_pick (
        .eligible   (eligible),
        .last_grant (last_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Select the winning requester's command fields for latching.
    always_comb begin
        write_d = cpu_write;
        addr_d  = cpu_address;
        wdata_d = cpu_wdata;
        if (pick_winner == PORT_LDR) begin
            write_d = ldr_write;
            addr_d  = ldr_address;
            wdata_d = ldr_wdata;
        end
    end

    // Arbitration FSM with latched command, read data and ack registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            winner_q  <= PORT_CPU;
            last_q    <= PORT_LDR;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cpu_ack_q <= 1'b0;
            ldr_ack_q <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            ldr_ack_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q  <= ST_ACCESS;
                        winner_q <= pick_winner;
                        last_q   <= pick_winner;
                        write_q  <= write_d;
                        addr_q   <= addr_d;
                        wdata_q  <= wdata_d;
                    end
                end
                ST_ACCESS: begin
                    // Captured on writes too, so rdata holds the pre-write word.
                    rdata_q <= memoryOut;
                    if (winner_q == PORT_CPU) begin
                        cpu_ack_q <= 1'b1;
                    end else begin
                        ldr_ack_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the memory only during ACCESS; reset gates the write so an
    // interrupted transaction never commits.
    always_comb begin
        address  = '0;
        memoryIn = '0;
        write    = 1'b0;
        if (state_q == ST_ACCESS) begin
            address  = addr_q;
            memoryIn = wdata_q;
            write    = write_q & ~reset;
        end
    end

    assign cpu_ack = cpu_ack_q;
    assign ldr_ack = ldr_ack_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed accesses push their expected
// (port, rdata) into a queue; a monitor pops and compares on every ack.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic       clk;
    logic       reset;
    logic       cpu_req, cpu_write, cpu_ack;
    logic [3:0] cpu_address;
    logic [7:0] cpu_wdata;
    logic       ldr_req, ldr_write, ldr_ack;
    logic [3:0] ldr_address;
    logic [7:0] ldr_wdata;
    logic [7:0] rdata;
    logic [3:0] address;
    logic       write;
    logic [7:0] memoryIn;
    logic [7:0] memoryOut;

    int checks = 0;
    int failures = 0;
    int wr_pulses = 0;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } exp_t;
    exp_t sb_q[$];

    // Memory model: 0:A0 2:B2 3:33 6:03, others 00.
    logic [7:0] mem [0:15] = '{8'hA0, 8'h00, 8'hB2, 8'h33, 8'h00, 8'h00, 8'h03, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    always @(posedge clk) if (write) mem[address] <= memoryIn;
    assign memoryOut = mem[address];

    memory_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_write   (cpu_write),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .ldr_req     (ldr_req),
        .ldr_write   (ldr_write),
        .ldr_address (ldr_address),
        .ldr_wdata   (ldr_wdata),
        .ldr_ack     (ldr_ack),
        .rdata       (rdata),
        .address     (address),
        .write       (write),
        .memoryIn    (memoryIn),
        .memoryOut   (memoryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expectation.
    always @(negedge clk) begin
        if (write) wr_pulses++;
        if (cpu_ack || ldr_ack) begin
            chk("ack_overlap", 32'(cpu_ack & ldr_ack), 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ack_port", 32'(ldr_ack), 32'(e.port));
                chk("ack_rdata", 32'(rdata), 32'(e.data));
            end
        end
    end

    task automatic expect_ack(input logic port, input logic [7:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic port, input logic req, input logic wr,
                         input logic [3:0] a, input logic [7:0] d);
        if (port == PORT_CPU) begin
            cpu_req = req; cpu_write = wr; cpu_address = a; cpu_wdata = d;
        end else begin
            ldr_req = req; ldr_write = wr; ldr_address = a; ldr_wdata = d;
        end
    endtask

    // Poll at posedge+1 until the given port acks (sel=2: either port).
    task automatic wait_ack(input int sel, input int bound, output int n);
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < bound) begin
            @(posedge clk);
            #1;
            n++;
            got = (sel == 0) ? cpu_ack : (sel == 1) ? ldr_ack : (cpu_ack | ldr_ack);
        end
        if (!got) chk("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic access(input logic port, input logic wr, input logic [3:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd);
        int n;
        expect_ack(port, exp_rd);
        drive(port, 1'b1, wr, a, d);
        wait_ack(port == PORT_CPU ? 0 : 1, 10, n);
        drive(port, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        reset = 1'b1;
        drive(PORT_CPU, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(PORT_LDR, 1'b0, 1'b0, 4'h0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_ldr_ack", 32'(ldr_ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_memoryIn", 32'(memoryIn), 32'd0);
        reset = 1'b0;

        // CPU read of address 6, latency 2 edges.
        expect_ack(PORT_CPU, 8'h03);
        drive(PORT_CPU, 1'b1, 1'b0, 4'd6, 8'h00);
        wait_ack(0, 10, n);
        chk("t1_latency", 32'(n), 32'd2);
        chk("t1_rdata", 32'(rdata), 32'h03);
        chk("t1_ldr_ack", 32'(ldr_ack), 32'd0);
        drive(PORT_CPU, 1'b0, 1'b0, 4'h0, 8'h00);
        @(posedge clk);
        #1;

        // Loader write then CPU read-back.
        p0 = wr_pulses;
        access(PORT_LDR, 1'b1, 4'd1, 8'h56, 8'h00);
        chk("t2_write_pulses", 32'(wr_pulses - p0), 32'd1);
        chk("t2_mem1", 32'(mem[1]), 32'h56);
        access(PORT_CPU, 1'b0, 4'd1, 8'h00, 8'h56);

        // Both ports continuously from reset: C, L, C, L at 2-cycle spacing.
        expect_ack(PORT_CPU, 8'hA0);
        expect_ack(PORT_LDR, 8'hB2);
        expect_ack(PORT_CPU, 8'hA0);
        expect_ack(PORT_LDR, 8'hB2);
        reset = 1'b1;
        drive(PORT_CPU, 1'b1, 1'b0, 4'd0, 8'h00);
        drive(PORT_LDR, 1'b1, 1'b0, 4'd2, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(2, 10, n);
            chk("t3_spacing", 32'(n), 32'd2);
        end
        drive(PORT_CPU, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(PORT_LDR, 1'b0, 1'b0, 4'h0, 8'h00);
        @(posedge clk);
        #1;

        // Single CPU holding req: 3-cycle period.
        expect_ack(PORT_CPU, 8'h03);
        expect_ack(PORT_CPU, 8'h03);
        drive(PORT_CPU, 1'b1, 1'b0, 4'd6, 8'h00);
        wait_ack(0, 10, n);
        chk("t4_first", 32'(n), 32'd2);
        @(posedge clk);
        #1;
        chk("t4_no_regrant", 32'(address), 32'd0);
        wait_ack(0, 10, n);
        chk("t4_period", 32'(n + 1), 32'd3);
        drive(PORT_CPU, 1'b0, 1'b0, 4'h0, 8'h00);

        // Loader write aborted by reset during ACCESS.
        drive(PORT_LDR, 1'b1, 1'b1, 4'd3, 8'hFF);
        @(posedge clk);
        #1;
        chk("t5_access_addr", 32'(address), 32'd3);
        chk("t5_access_write", 32'(write), 32'd1);
        reset = 1'b1;
        drive(PORT_LDR, 1'b0, 1'b0, 4'h0, 8'h00);
        #1;
        chk("t5_write_gated", 32'(write), 32'd0);
        @(posedge clk);
        #1;
        chk("t5_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("t5_ldr_ack", 32'(ldr_ack), 32'd0);
        chk("t5_rdata", 32'(rdata), 32'd0);
        chk("t5_address", 32'(address), 32'd0);
        chk("t5_memoryIn", 32'(memoryIn), 32'd0);
        chk("t5_mem3", 32'(mem[3]), 32'h33);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_no_ack", 32'(ldr_ack), 32'd0);

        // CPU request arriving while the loader is in ACCESS.
        expect_ack(PORT_LDR, 8'hB2);
        expect_ack(PORT_CPU, 8'h03);
        drive(PORT_LDR, 1'b1, 1'b0, 4'd2, 8'h00);
        @(posedge clk);
        #1;
        drive(PORT_CPU, 1'b1, 1'b0, 4'd6, 8'h00);
        @(posedge clk);
        #1;
        chk("t6_ldr_ack", 32'(ldr_ack), 32'd1);
        chk("t6_cpu_ack_early", 32'(cpu_ack), 32'd0);
        drive(PORT_LDR, 1'b0, 1'b0, 4'h0, 8'h00);
        @(posedge clk);
        #1;
        chk("t6_cpu_access", 32'(address), 32'd6);
        @(posedge clk);
        #1;
        chk("t6_cpu_ack", 32'(cpu_ack), 32'd1);
        drive(PORT_CPU, 1'b0, 1'b0, 4'h0, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
